// File: rtl/fifo_param_pkg.sv
// Shared FIFO definitions: width helper, default geometries and the flag bundle.
// Imported by fifo_param and fifo_mem; holds no logic of its own.
package fifo_param_pkg;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_DEPTH       = 16;
   localparam int UART_FIFO_WIDTH = 8;
   localparam int UART_FIFO_DEPTH = 16;
   localparam int GPIO_FIFO_WIDTH = 32;
   localparam int GPIO_FIFO_DEPTH = 8;

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_empty;
      logic almost_full;
   } fifo_flags_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the pointer logic never exposes stale words.
module fifo_mem
   import fifo_param_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_W     = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// Single-clock FIFO with occupancy flags; registered or fall-through read, one-cycle write-to-visible latency.
// Writes to a full FIFO and reads from an empty one are dropped and flagged with one-cycle pulses.
module fifo_param
   import fifo_param_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  writeEn,
   input  logic                  readEn,
   input  logic [DATA_WIDTH-1:0] dataIn,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  Empty,
   output logic                  Full,
   output logic                  AlmostEmpty,
   output logic                  AlmostFull,
   output logic [clog2(DEPTH):0] count,
   output logic                  Overflow,
   output logic                  Underflow
);

   localparam int ADDR_W = clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;
   localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AF_CNT   = PTR_W'(AF_LEVEL);
   localparam logic [PTR_W-1:0] AE_CNT   = PTR_W'(AE_LEVEL);

   logic [PTR_W-1:0]      wptr_q, wptr_d;
   logic [PTR_W-1:0]      rptr_q, rptr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic [PTR_W-1:0]      occ;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rd_acc;
   logic                  wr_acc;
   fifo_flags_t           flags;

   // The extra pointer MSB distinguishes full from empty when the addresses match.
   assign occ = wptr_q - rptr_q;

   always_comb begin
      flags              = '0;
      flags.empty        = (occ == '0);
      flags.full         = (occ == FULL_CNT);
      flags.almost_empty = (occ <= AE_CNT);
      flags.almost_full  = (occ >= AF_CNT);
   end

   assign rd_acc = readEn && !flags.empty;
   assign wr_acc = writeEn && (!flags.full || rd_acc);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      dout_d = dout_q;
      ovf_d  = writeEn && !wr_acc;
      udf_d  = readEn && !rd_acc;
      if (wr_acc) begin
         wptr_d = wptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
         rptr_d = rptr_q + PTR_W'(1);
      end
      // Fall-through mode tracks the head so the last shown word survives going empty.
      if (FWFT != 0) begin
         if (!flags.empty) begin
            dout_d = rdata;
         end
      end else if (rd_acc) begin
         dout_d = rdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         dout_q <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         dout_q <= dout_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_acc),
      .waddr_i (wptr_q[ADDR_W-1:0]),
      .wdata_i (dataIn),
      .raddr_i (rptr_q[ADDR_W-1:0]),
      .rdata_o (rdata)
   );

   assign dataOut     = ((FWFT != 0) && !flags.empty) ? rdata : dout_q;
   assign Empty       = flags.empty;
   assign Full        = flags.full;
   assign AlmostEmpty = flags.almost_empty;
   assign AlmostFull  = flags.almost_full;
   assign count       = occ;
   assign Overflow    = ovf_q;
   assign Underflow   = udf_q;

endmodule
